corr_scan_scheduler: RTL and testbench

Synchronous sequencer for the correlation engine. Once a stored frame is ready, it sweeps a rectangular grid of candidate (X,Y) offsets and issues one start/done job per point to the correlator. It tracks the peak correlation and its coordinates, and reports completion, timeout and heartbeat status. It sits between the frame-save logic and the correlator datapath, and its results feed display/LED logic.

---
 rtl/corr_scan_scheduler_if.sv | 33 +++
 rtl/corr_scan_scheduler.sv | 159 +++++++++++++++
 tb/tb_corr_scan_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corr_scan_scheduler_if.sv
// Frame/correlator handshake and result bus of the correlation scan scheduler.
// The master side is the scheduler; the slave side is the frame logic plus the correlator.
interface corr_scan_scheduler_if #(
  parameter int unsigned CORR_W = 32
);
  localparam int unsigned COORD_W = 12;

  logic               iFrameDone;
  logic               iCorrDone;
  logic [CORR_W-1:0]  iCorrValue;
  logic               oCorrStart;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic [COORD_W-1:0] oXresult;
  logic [COORD_W-1:0] oYresult;
  logic [CORR_W-1:0]  oPeakCorr;
  logic               oBusy;
  logic               oFinished;
  logic               oTimeout;
  logic               oStatusLed;

  modport master (
    input  iFrameDone, iCorrDone, iCorrValue,
    output oCorrStart, oX, oY, oXresult, oYresult, oPeakCorr,
           oBusy, oFinished, oTimeout, oStatusLed
  );

  modport slave (
    output iFrameDone, iCorrDone, iCorrValue,
    input  oCorrStart, oX, oY, oXresult, oYresult, oPeakCorr,
           oBusy, oFinished, oTimeout, oStatusLed
  );
endinterface

// File: rtl/corr_scan_scheduler.sv
// Correlation scan sequencer: sweeps an X/Y offset grid issuing one correlator job per
// point, tracks the peak result and reports finished/timeout/heartbeat status.
module corr_scan_scheduler #(
  parameter logic [11:0] X_MAX    = 12'd639,
  parameter logic [11:0] Y_MAX    = 12'd479,
  parameter logic [11:0] STEP     = 12'd1,
  parameter int unsigned CORR_W   = 32,
  parameter logic [19:0] TIMEOUT  = 20'hFFFFF,
  parameter int unsigned LED_BITS = 25
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  corr_scan_scheduler_if.master bus
);
  localparam int unsigned COORD_W = 12;
  localparam int unsigned TO_W    = 20;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

  state_t              state, stateNext;
  logic                frameDonePrev;
  logic                frameRise;
  logic                firstResult, firstResultNext;
  logic [CORR_W-1:0]   corrVal, corrValNext, peakNext;
  logic [COORD_W-1:0]  xNext, yNext, xResNext, yResNext;
  logic [TO_W-1:0]     toCnt, toCntNext;
  logic [LED_BITS-1:0] ledCnt, ledCntNext;
  logic                timeoutNext;
  logic                busyNext;
  logic [COORD_W:0]    xStep, yStep;

  // Previous-value compare: a level already high at reset release is not an edge.
  assign frameRise = bus.iFrameDone & ~frameDonePrev;
  assign xStep     = {1'b0, bus.oX} + {1'b0, STEP};
  assign yStep     = {1'b0, bus.oY} + {1'b0, STEP};
  assign busyNext  = (stateNext == ISSUE) || (stateNext == WAIT) || (stateNext == UPDATE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext       = state;
    xNext           = bus.oX;
    yNext           = bus.oY;
    xResNext        = bus.oXresult;
    yResNext        = bus.oYresult;
    peakNext        = bus.oPeakCorr;
    firstResultNext = firstResult;
    corrValNext     = corrVal;
    toCntNext       = toCnt;
    timeoutNext     = bus.oTimeout;
    ledCntNext      = ledCnt;

    case (state)
      IDLE: begin
        if (frameRise) begin
          xNext           = '0;
          yNext           = '0;
          xResNext        = '0;
          yResNext        = '0;
          peakNext        = '0;
          firstResultNext = 1'b1;
          timeoutNext     = 1'b0;
          stateNext       = ISSUE;
        end
      end
      ISSUE: begin
        toCntNext = '0;
        stateNext = bus.iFrameDone ? WAIT : IDLE;
      end
      WAIT: begin
        if (!bus.iFrameDone) begin
          stateNext = IDLE;
        end else if (bus.iCorrDone) begin
          corrValNext = bus.iCorrValue;
          stateNext   = UPDATE;
        end else begin
          toCntNext = toCnt + TO_W'(1);
          if (toCntNext == TIMEOUT) begin
            timeoutNext = 1'b1;
            stateNext   = DONE;
          end
        end
      end
      UPDATE: begin
        if (!bus.iFrameDone) begin
          stateNext = IDLE;
        end else begin
          // Strict compare keeps the earliest coordinate on ties.
          if (firstResult || (corrVal > bus.oPeakCorr)) begin
            peakNext        = corrVal;
            xResNext        = bus.oX;
            yResNext        = bus.oY;
            firstResultNext = 1'b0;
          end
          if (xStep <= {1'b0, X_MAX}) begin
            xNext     = xStep[COORD_W-1:0];
            stateNext = ISSUE;
          end else if (yStep <= {1'b0, Y_MAX}) begin
            xNext     = '0;
            yNext     = yStep[COORD_W-1:0];
            stateNext = ISSUE;
          end else begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.iFrameDone) begin
          timeoutNext = 1'b0;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Heartbeat divider runs only while busy, cleared whenever idle.
    if (stateNext == IDLE) ledCntNext = '0;
    else if (busyNext)     ledCntNext = ledCnt + LED_BITS'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frameDonePrev  <= 1'b1;
      firstResult    <= 1'b0;
      corrVal        <= '0;
      toCnt          <= '0;
      ledCnt         <= '0;
      bus.oX         <= '0;
      bus.oY         <= '0;
      bus.oXresult   <= '0;
      bus.oYresult   <= '0;
      bus.oPeakCorr  <= '0;
      bus.oCorrStart <= 1'b0;
      bus.oBusy      <= 1'b0;
      bus.oFinished  <= 1'b0;
      bus.oTimeout   <= 1'b0;
      bus.oStatusLed <= 1'b0;
    end else begin
      frameDonePrev  <= bus.iFrameDone;
      firstResult    <= firstResultNext;
      corrVal        <= corrValNext;
      toCnt          <= toCntNext;
      ledCnt         <= ledCntNext;
      bus.oX         <= xNext;
      bus.oY         <= yNext;
      bus.oXresult   <= xResNext;
      bus.oYresult   <= yResNext;
      bus.oPeakCorr  <= peakNext;
      bus.oCorrStart <= (stateNext == ISSUE);
      bus.oBusy      <= busyNext;
      bus.oFinished  <= (stateNext == DONE);
      bus.oTimeout   <= timeoutNext;
      bus.oStatusLed <= (stateNext == DONE) | (busyNext & ledCntNext[LED_BITS-1]);
    end
  end
endmodule

// File: tb/tb_corr_scan_scheduler.sv
// Bench for corr_scan_scheduler: two instances (4x3 grid step 1, 6x5 grid step 2) driven
// by a correlator responder, checked against a grid/peak reference model.
module tb_corr_scan_scheduler;
  localparam int TO_CYC = 16;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          x;
    int          y;
    int          cyc;
    int          lat;
    int unsigned val;
    bit          silent;
  } job_t;

  job_t jobQ[$];
  int   expX[$];
  int   expY[$];

  int checks   = 0;
  int failures = 0;

  logic [1:0]  frameDone = '0;
  int          valMode[2];
  int unsigned constVal[2];
  bit          randLat[2];
  int          silentJob[2];
  int          jobIdx[2];

  logic [1:0]  busy, finished, timeoutO, led, corrStart;
  logic [11:0] xCur[2];
  logic [11:0] xRes[2];
  logic [11:0] yRes[2];
  logic [31:0] peak[2];

  for (genvar g = 0; g < 2; g++) begin : g_env
    corr_scan_scheduler_if #(.CORR_W(32)) bus ();

    corr_scan_scheduler #(
      .X_MAX   (g == 0 ? 12'd3 : 12'd5),
      .Y_MAX   (g == 0 ? 12'd2 : 12'd4),
      .STEP    (g == 0 ? 12'd1 : 12'd2),
      .CORR_W  (32),
      .TIMEOUT (20'd16),
      .LED_BITS(4)
    ) dut (
      .iCLK  (clk),
      .iRST_N(rstN),
      .bus   (bus.master)
    );

    assign bus.iFrameDone = frameDone[g];
    assign busy[g]        = bus.oBusy;
    assign finished[g]    = bus.oFinished;
    assign timeoutO[g]    = bus.oTimeout;
    assign led[g]         = bus.oStatusLed;
    assign corrStart[g]   = bus.oCorrStart;
    assign xCur[g]        = bus.oX;
    assign xRes[g]        = bus.oXresult;
    assign yRes[g]        = bus.oYresult;
    assign peak[g]        = bus.oPeakCorr;

    // Correlator model: records each start, replies lat cycles later unless told to stay silent.
    initial begin : responder
      job_t j;
      bus.iCorrDone  = 1'b0;
      bus.iCorrValue = '0;
      forever begin
        @(negedge clk);
        if (bus.oCorrStart === 1'b1) begin
          j.x      = int'(bus.oX);
          j.y      = int'(bus.oY);
          j.cyc    = cyc;
          j.lat    = randLat[g] ? int'($urandom_range(1, 4)) : 3;
          j.val    = (valMode[g] == 0) ? 32'(10 * j.y + j.x) :
                     (valMode[g] == 1) ? constVal[g] : $urandom_range(0, 15);
          j.silent = (jobIdx[g] == silentJob[g]);
          jobIdx[g] = jobIdx[g] + 1;
          jobQ.push_back(j);
          if (!j.silent) begin
            repeat (j.lat) @(posedge clk);
            #1;
            bus.iCorrDone  = 1'b1;
            bus.iCorrValue = j.val;
            @(posedge clk);
            #1;
            bus.iCorrDone  = 1'b0;
            bus.iCorrValue = $urandom;
          end
        end
      end
    end
  end

  // Raster enumeration of the expected sweep.
  function automatic void build_grid(input int xm, input int ym, input int st);
    expX.delete();
    expY.delete();
    for (int y = 0; y <= ym; y += st)
      for (int x = 0; x <= xm; x += st) begin
        expX.push_back(x);
        expY.push_back(y);
      end
  endfunction

  // Peak over the first n answered jobs: first result always taken, then strictly greater.
  function automatic void model_peak(input int n, output int px, output int py,
                                     output int unsigned pv);
    bit first = 1'b1;
    px = 0; py = 0; pv = 0;
    for (int k = 0; k < n && k < jobQ.size() && k < expX.size(); k++) begin
      if (!jobQ[k].silent && (first || jobQ[k].val > pv)) begin
        pv = jobQ[k].val; px = expX[k]; py = expY[k]; first = 1'b0;
      end
    end
  endfunction

  task automatic setup(input int g, input int mode, input bit rl, input int silent);
    jobQ.delete();
    jobIdx[g]    = 0;
    valMode[g]   = mode;
    randLat[g]   = rl;
    silentJob[g] = silent;
  endtask

  task automatic start_scan(input int g);
    @(posedge clk); #1 frameDone[g] = 1'b0;
    @(posedge clk); #1 frameDone[g] = 1'b1;
  endtask

  task automatic stop_scan(input int g);
    @(posedge clk); #1 frameDone[g] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_finish(input int g, input int budget, output int doneCyc, output bit ledSeen);
    doneCyc = -1;
    ledSeen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy[g] && led[g]) ledSeen = 1'b1;
      if (finished[g]) begin
        doneCyc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], finished[g], timeoutO[g], led[g], corrStart[g]} !== 5'b0 ||
          xCur[g] !== 12'd0 || xRes[g] !== 12'd0 || yRes[g] !== 12'd0 || peak[g] !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs env%0d: flags=%b x=%0d xr=%0d yr=%0d peak=%0d, expected all 0",
                 g, {busy[g], finished[g], timeoutO[g], led[g], corrStart[g]}, xCur[g], xRes[g], yRes[g], peak[g]);
      end
    end
  endtask

  task automatic test_raster();
    int dc, px, py, n; int unsigned pv; bit ls;
    setup(0, 0, 1'b0, -1);
    build_grid(3, 2, 1);
    start_scan(0);
    wait_finish(0, 500, dc, ls);
    checks++;
    if (dc < 0) begin failures++; $display("FAIL raster_finish: oFinished never rose, expected 1"); end
    checks++;
    if (jobQ.size() != expX.size()) begin
      failures++; $display("FAIL raster_jobs: got %0d starts, expected %0d", jobQ.size(), expX.size());
    end
    n = (jobQ.size() < expX.size()) ? jobQ.size() : expX.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (jobQ[k].x != expX[k] || jobQ[k].y != expY[k]) begin
        failures++; $display("FAIL raster_coord job%0d: got (%0d,%0d) expected (%0d,%0d)",
                             k, jobQ[k].x, jobQ[k].y, expX[k], expY[k]);
      end
    end
    for (int k = 0; k + 1 < n; k++) begin
      checks++;
      if (jobQ[k+1].cyc - jobQ[k].cyc != jobQ[k].lat + 2) begin
        failures++; $display("FAIL raster_spacing job%0d: got %0d cycles expected %0d",
                             k, jobQ[k+1].cyc - jobQ[k].cyc, jobQ[k].lat + 2);
      end
    end
    model_peak(n, px, py, pv);
    checks++;
    if (xRes[0] !== 12'(px) || yRes[0] !== 12'(py) || peak[0] !== 32'(pv)) begin
      failures++; $display("FAIL raster_peak: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                           xRes[0], yRes[0], peak[0], px, py, pv);
    end
    checks++;
    if ({finished[0], timeoutO[0], led[0], busy[0]} !== 4'b1010) begin
      failures++; $display("FAIL raster_status: fin/to/led/busy=%b expected 1010",
                           {finished[0], timeoutO[0], led[0], busy[0]});
    end
    checks++;
    if (ls !== 1'b1) begin failures++; $display("FAIL raster_heartbeat: led high while busy=%0b expected 1", ls); end
    stop_scan(0);
    checks++;
    if ({finished[0], timeoutO[0], led[0], busy[0]} !== 4'b0000) begin
      failures++; $display("FAIL raster_idle: fin/to/led/busy=%b expected 0000",
                           {finished[0], timeoutO[0], led[0], busy[0]});
    end
  endtask

  task automatic test_ties();
    int dc, px, py; int unsigned pv; bit ls;
    int unsigned tieVals[2] = '{5, 0};
    for (int t = 0; t < 2; t++) begin
      setup(0, 1, 1'b0, -1);
      constVal[0] = tieVals[t];
      build_grid(3, 2, 1);
      start_scan(0);
      wait_finish(0, 500, dc, ls);
      model_peak(expX.size(), px, py, pv);
      checks++;
      if (dc < 0 || jobQ.size() != expX.size() || xRes[0] !== 12'(px) || yRes[0] !== 12'(py) ||
          peak[0] !== 32'(pv)) begin
        failures++; $display("FAIL ties_%0d: fin_cyc=%0d jobs=%0d peak (%0d,%0d)=%0d expected jobs=%0d (%0d,%0d)=%0d",
                             tieVals[t], dc, jobQ.size(), xRes[0], yRes[0], peak[0], expX.size(), px, py, pv);
      end
      stop_scan(0);
    end
  endtask

  task automatic test_random();
    int dc, px, py, n; int unsigned pv; bit ls; int bad;
    for (int r = 0; r < 3; r++) begin
      setup(0, 2, 1'b1, -1);
      build_grid(3, 2, 1);
      start_scan(0);
      wait_finish(0, 500, dc, ls);
      n = (jobQ.size() < expX.size()) ? jobQ.size() : expX.size();
      bad = 0;
      for (int k = 0; k + 1 < n; k++)
        if (jobQ[k+1].cyc - jobQ[k].cyc != jobQ[k].lat + 2) bad++;
      checks++;
      if (dc < 0 || jobQ.size() != expX.size() || bad != 0) begin
        failures++; $display("FAIL random_seq%0d: fin_cyc=%0d jobs=%0d bad_spacing=%0d expected jobs=%0d bad_spacing=0",
                             r, dc, jobQ.size(), bad, expX.size());
      end
      model_peak(n, px, py, pv);
      checks++;
      if (xRes[0] !== 12'(px) || yRes[0] !== 12'(py) || peak[0] !== 32'(pv)) begin
        failures++; $display("FAIL random_peak%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                             r, xRes[0], yRes[0], peak[0], px, py, pv);
      end
      stop_scan(0);
    end
  endtask

  task automatic test_step();
    int dc, px, py, n, outOfRange; int unsigned pv; bit ls;
    setup(1, 2, 1'b1, -1);
    build_grid(5, 4, 2);
    start_scan(1);
    wait_finish(1, 500, dc, ls);
    checks++;
    if (dc < 0 || jobQ.size() != expX.size()) begin
      failures++; $display("FAIL step_jobs: fin_cyc=%0d got %0d starts expected %0d", dc, jobQ.size(), expX.size());
    end
    n = (jobQ.size() < expX.size()) ? jobQ.size() : expX.size();
    outOfRange = 0;
    for (int k = 0; k < jobQ.size(); k++)
      if (jobQ[k].x > 5 || jobQ[k].y > 4) outOfRange++;
    checks++;
    if (outOfRange != 0) begin
      failures++; $display("FAIL step_range: got %0d out-of-range starts expected 0", outOfRange);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (jobQ[k].x != expX[k] || jobQ[k].y != expY[k]) begin
        failures++; $display("FAIL step_coord job%0d: got (%0d,%0d) expected (%0d,%0d)",
                             k, jobQ[k].x, jobQ[k].y, expX[k], expY[k]);
      end
    end
    model_peak(n, px, py, pv);
    checks++;
    if (xRes[1] !== 12'(px) || yRes[1] !== 12'(py) || peak[1] !== 32'(pv)) begin
      failures++; $display("FAIL step_peak: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                           xRes[1], yRes[1], peak[1], px, py, pv);
    end
    stop_scan(1);
  endtask

  task automatic test_timeout();
    int dc, px, py; int unsigned pv; bit ls;
    setup(0, 0, 1'b0, 2);
    build_grid(3, 2, 1);
    start_scan(0);
    wait_finish(0, 300, dc, ls);
    checks++;
    if (dc < 0 || jobQ.size() != 3) begin
      failures++; $display("FAIL timeout_finish: fin_cyc=%0d jobs=%0d expected finish after 3 jobs", dc, jobQ.size());
    end else begin
      // WAIT lasts TIMEOUT cycles after the start cycle of the silent job.
      checks++;
      if (dc - jobQ[2].cyc != TO_CYC + 1) begin
        failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d", dc - jobQ[2].cyc, TO_CYC + 1);
      end
    end
    model_peak(2, px, py, pv);
    checks++;
    if (timeoutO[0] !== 1'b1 || xRes[0] !== 12'(px) || yRes[0] !== 12'(py) || peak[0] !== 32'(pv)) begin
      failures++; $display("FAIL timeout_result: to=%0b (%0d,%0d)=%0d expected to=1 (%0d,%0d)=%0d",
                           timeoutO[0], xRes[0], yRes[0], peak[0], px, py, pv);
    end
    stop_scan(0);
    checks++;
    if (timeoutO[0] !== 1'b0 || finished[0] !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: to=%0b fin=%0b expected 0 0", timeoutO[0], finished[0]);
    end
  endtask

  task automatic test_abort();
    int dc, px, py, i; int unsigned pv; bit ls;
    setup(0, 0, 1'b0, -1);
    build_grid(3, 2, 1);
    start_scan(0);
    for (i = 0; i < 200 && jobQ.size() < 5; i++) @(posedge clk);
    #1 frameDone[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || jobQ.size() != 5) begin
      failures++; $display("FAIL abort_idle: busy=%0b jobs=%0d expected busy=0 jobs=5", busy[0], jobQ.size());
    end
    repeat (12) @(negedge clk);
    checks++;
    if (jobQ.size() != 5 || finished[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL abort_quiet: jobs=%0d fin=%0b busy=%0b expected 5 0 0", jobQ.size(), finished[0], busy[0]);
    end
    setup(0, 0, 1'b0, -1);
    start_scan(0);
    wait_finish(0, 500, dc, ls);
    model_peak(expX.size(), px, py, pv);
    checks++;
    if (dc < 0 || jobQ.size() != expX.size() || jobQ[0].x != 0 || jobQ[0].y != 0 ||
        xRes[0] !== 12'(px) || yRes[0] !== 12'(py) || peak[0] !== 32'(pv)) begin
      failures++; $display("FAIL abort_restart: fin_cyc=%0d jobs=%0d peak (%0d,%0d)=%0d expected jobs=%0d from (0,0) peak (%0d,%0d)=%0d",
                           dc, jobQ.size(), xRes[0], yRes[0], peak[0], expX.size(), px, py, pv);
    end
    stop_scan(0);
  endtask

  task automatic test_async_reset();
    int dc, n0; bit ls;
    setup(0, 0, 1'b0, -1);
    build_grid(3, 2, 1);
    start_scan(0);
    for (int i = 0; i < 200 && jobQ.size() < 3; i++) @(posedge clk);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({busy[0], finished[0], led[0], corrStart[0]} !== 4'b0 || xCur[0] !== 12'd0 ||
        peak[0] !== 32'd0 || xRes[0] !== 12'd0) begin
      failures++; $display("FAIL async_reset: flags=%b x=%0d peak=%0d xr=%0d expected all 0",
                           {busy[0], finished[0], led[0], corrStart[0]}, xCur[0], peak[0], xRes[0]);
    end
    @(posedge clk); #1 rstN = 1'b1;
    n0 = jobQ.size();
    repeat (20) @(negedge clk);
    checks++;
    if (jobQ.size() != n0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL reset_level_start: jobs=%0d busy=%0b expected %0d 0", jobQ.size(), busy[0], n0);
    end
    setup(0, 0, 1'b0, -1);
    start_scan(0);
    wait_finish(0, 500, dc, ls);
    checks++;
    if (dc < 0 || jobQ.size() != expX.size() || jobQ[0].x != 0 || jobQ[0].y != 0) begin
      failures++; $display("FAIL reset_restart: fin_cyc=%0d jobs=%0d expected %0d jobs from (0,0)", dc, jobQ.size(), expX.size());
    end
    stop_scan(0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      valMode[g] = 0; constVal[g] = 0; randLat[g] = 1'b0; silentJob[g] = -1; jobIdx[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rstN = 1'b1;
    repeat (2) @(posedge clk);
    test_raster();
    test_ties();
    test_random();
    test_step();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
